// File: rtl/instruction_cache_if.sv
// CPU-fetch and instruction-memory signal bundle for instruction_cache.
// slave = cache side, master = the CPU/memory environment driving it.
interface instruction_cache_if;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    modport slave (
        input  read, address, mem_readinst, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, mem_readinst, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines x 128 bits, 3-bit tag.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache (
    input  logic                 clock,
    input  logic                 reset,
    instruction_cache_if.slave   bus,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [127:0] data [0:7];
    logic [2:0]   tags [0:7];
    logic [7:0]   valid;
    logic [5:0]   miss_addr;

    logic [2:0]   tag;
    logic [2:0]   index;
    logic [1:0]   word;
    logic         hit;
    logic [127:0] line;
    logic [31:0]  word_data;
    logic         mem_read_c;
    logic [5:0]   mem_address_c;
    logic         unused_bits;

    assign tag         = bus.address[9:7];
    assign index       = bus.address[6:4];
    assign word        = bus.address[3:2];
    assign unused_bits = ^bus.address[1:0];

    // Hit detection and word selection from the indexed line
    always_comb begin
        line = data[index];
        hit  = bus.read && valid[index] && (tags[index] == tag);
        case (word)
            2'd0:    word_data = line[31:0];
            2'd1:    word_data = line[63:32];
            2'd2:    word_data = line[95:64];
            2'd3:    word_data = line[127:96];
            default: word_data = 32'h0;
        endcase
    end

    assign bus.instruction = hit ? word_data : 32'h0;
    // Reset dominates so the CPU is never stalled while the cache is being cleared
    assign bus.busywait    = reset ? 1'b0
                           : ((bus.read && !hit && (state == IDLE)) || (state != IDLE));
    assign bus.mem_read    = mem_read_c;
    assign bus.mem_address = mem_address_c;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state and memory request outputs
    always_comb begin
        next_state    = state;
        mem_read_c    = 1'b0;
        mem_address_c = 6'd0;
        case (state)
            IDLE: begin
                if (bus.read && !hit) begin
                    next_state = MEM_READ;
                end else begin
                    next_state = IDLE;
                end
            end
            MEM_READ: begin
                mem_read_c    = 1'b1;
                mem_address_c = miss_addr;
                if (!bus.mem_busywait) begin
                    next_state = UPDATE;
                end else begin
                    next_state = MEM_READ;
                end
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Miss address latch and valid bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= 8'h00;
            miss_addr <= 6'd0;
        end else begin
            if ((state == IDLE) && bus.read && !hit) begin
                miss_addr <= {tag, index};
            end
            if (state == UPDATE) begin
                valid[miss_addr[2:0]] <= 1'b1;
            end
        end
    end

    // Line data and tag install; contents are meaningless until valid is set
    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            data[miss_addr[2:0]] <= bus.mem_readinst;
            tags[miss_addr[2:0]] <= miss_addr[5:3];
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit and miss statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else if (state == IDLE) begin
            if (hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'h0001;
            end
            if (bus.read && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'h0001;
            end
        end
    end
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a small
// latency-modelled instruction memory.
module tb_instruction_cache;
    logic        clock;
    logic        reset;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    instruction_cache_if bus();

    instruction_cache dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory raises busywait as soon as a read is requested, answers after 3 edges
    logic       mem_ready;
    logic [1:0] mem_cnt;
    logic [127:0] mem_data;
    assign bus.mem_busywait = bus.mem_read && !mem_ready;
    assign bus.mem_readinst = mem_data;

    function automatic logic [127:0] block_of(input logic [5:0] a);
        case (a)
            6'd0:    block_of = {32'h0001005A, 32'h02060405, 32'h00050023, 32'h00040019};
            6'd1:    block_of = {32'h11111111, 32'h22222222, 32'h33333333, 32'h03010104};
            default: block_of = {4{32'hA5A50000 | {26'd0, a}}};
        endcase
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_cnt   = 2'd0;
        mem_data  = 128'd0;
    end

    always @(posedge clock) begin
        if (!bus.mem_read) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 2'd0;
        end else if (!mem_ready) begin
            if (mem_cnt == 2'd2) begin
                mem_ready <= 1'b1;
                mem_data  <= block_of(bus.mem_address);
            end else begin
                mem_cnt <= mem_cnt + 2'd1;
            end
        end
    end

    // Count distinct memory requests and remember the last block address
    int         req_count = 0;
    logic [5:0] last_req  = 6'd0;
    logic       prev_mem_read = 1'b0;
    always @(posedge clock) begin
        if (bus.mem_read && !prev_mem_read) begin
            req_count <= req_count + 1;
            last_req  <= bus.mem_address;
        end
        prev_mem_read <= bus.mem_read;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [9:0] a, output logic [31:0] ins, output logic missed);
        int n;
        @(negedge clock);
        bus.address = a;
        bus.read    = 1'b1;
        #1;
        missed = bus.busywait;
        n = 0;
        while (bus.busywait === 1'b1 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 50) check_eq("fetch_timeout", 32'(bus.busywait), 32'd0);
        ins = bus.instruction;
    endtask

    logic [31:0] ins;
    logic        missed;
    int          req_before;

    initial begin
        reset       = 1'b1;
        bus.read    = 1'b0;
        bus.address = 10'd0;
        #1;
        check_eq("rst_busywait",    32'(bus.busywait), 32'd0);
        check_eq("rst_mem_read",    32'(bus.mem_read), 32'd0);
        check_eq("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check_eq("rst_instruction", bus.instruction, 32'd0);
        check_eq("rst_hit_count",   32'(hit_count), 32'd0);
        bus.read = 1'b1;
        #1;
        check_eq("rst_busy_forced", 32'(bus.busywait), 32'd0);
        bus.read = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Cold miss
        fetch(10'd0, ins, missed);
        check_eq("cold_missed", 32'(missed), 32'd1);
        check_eq("cold_instr",  ins, 32'h00040019);
        check_eq("cold_reqs",   32'(req_count), 32'd1);
        check_eq("cold_addr",   32'(last_req), 32'd0);

        // Sequential hits
        fetch(10'd4, ins, missed);
        check_eq("hit4_missed", 32'(missed), 32'd0);
        check_eq("hit4_instr",  ins, 32'h00050023);
        fetch(10'd8, ins, missed);
        check_eq("hit8_missed", 32'(missed), 32'd0);
        check_eq("hit8_instr",  ins, 32'h02060405);
        fetch(10'd12, ins, missed);
        check_eq("hit12_missed", 32'(missed), 32'd0);
        check_eq("hit12_instr",  ins, 32'h0001005A);
        check_eq("hits_no_req",  32'(req_count), 32'd1);

        // Next block
        fetch(10'd16, ins, missed);
        check_eq("blk1_missed", 32'(missed), 32'd1);
        check_eq("blk1_instr",  ins, 32'h03010104);
        check_eq("blk1_addr",   32'(last_req), 32'd1);
`ifdef ICACHE_STATS_EN
        check_eq("stats_hits",   32'(hit_count), 32'd4);
        check_eq("stats_misses", 32'(miss_count), 32'd2);
`endif
        fetch(10'd0, ins, missed);
        check_eq("blk0_rehit",  32'(missed), 32'd0);
        check_eq("blk0_instr",  ins, 32'h00040019);
        check_eq("blk0_no_req", 32'(req_count), 32'd2);

        // Conflict eviction on index 0
        fetch(10'h080, ins, missed);
        check_eq("evict_missed", 32'(missed), 32'd1);
        check_eq("evict_addr",   32'(last_req), 32'd8);
        check_eq("evict_instr",  ins, 32'hA5A50008);
        fetch(10'd0, ins, missed);
        check_eq("refetch_missed", 32'(missed), 32'd1);
        check_eq("refetch_addr",   32'(last_req), 32'd0);
        check_eq("refetch_reqs",   32'(req_count), 32'd4);
        check_eq("refetch_instr",  ins, 32'h00040019);

        // Reset in the middle of a refill
        @(negedge clock);
        bus.address = 10'h090;
        bus.read    = 1'b1;
        @(negedge clock);
        #1;
        check_eq("mid_mem_read", 32'(bus.mem_read), 32'd1);
        req_before = req_count;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("mid_rst_busywait", 32'(bus.busywait), 32'd0);
        check_eq("mid_rst_hit_count",  32'(hit_count), 32'd0);
        check_eq("mid_rst_miss_count", 32'(miss_count), 32'd0);
        @(negedge clock);
        bus.read = 1'b0;
        reset    = 1'b0;
        fetch(10'd0, ins, missed);
        check_eq("post_rst_missed", 32'(missed), 32'd1);
        check_eq("post_rst_instr",  ins, 32'h00040019);
        check_eq("post_rst_reqs",   32'(req_count), req_before + 1);

        @(negedge clock);
        bus.read = 1'b0;
        #1;
        check_eq("idle_busywait", 32'(bus.busywait), 32'd0);
        check_eq("idle_instr",    bus.instruction, 32'd0);
`ifndef ICACHE_STATS_EN
        check_eq("nostats_hits",   32'(hit_count), 32'd0);
        check_eq("nostats_misses", 32'(miss_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
